if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V core.
- Owns the program counter and drives address and chip-enable to the combinational instruction ROM. The ROM returns its instruction in the same cycle.
- Captures the PC/instruction pair into the IF/ID pipeline register consumed by the decode stage.
- Handles pipeline stall, exception flush, taken-branch redirect with wrong-path squash, and target misalignment detection.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset release
ADDR_W, 32, PC / address width
INST_W, 32, instruction width

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID
flush  in  1  exception flush from ctrl
new_pc  in  ADDR_W  exception handler address, valid with flush
branch_flag_i  in  1  taken branch/jump from ID (combinational, current cycle)
branch_target_address_i  in  ADDR_W  branch/jump target
inst_i  in  INST_W  instruction word from ROM
pc_o  out  ADDR_W  fetch address to ROM
ce_o  out  1  ROM chip enable
id_pc_o  out  ADDR_W  PC of the instruction in ID
id_inst_o  out  INST_W  instruction in ID
misaligned_o  out  1  one-cycle pulse: redirect target not word-aligned
fetch_count_o  out  32  count of instructions delivered to ID

Behaviour:
- Every register updates on the rising edge of clk. rst has priority over all other inputs.
- Reset values: ce_o=0, pc_o=RESET_PC, id_pc_o=0, id_inst_o=0, misaligned_o=0, fetch_count_o=0.
- ce_o: 0 while rst is high, then 1 from the first edge after release. While ce_o=0, pc_o is held at RESET_PC.
- First fetch: the first edge with rst low sets ce_o=1 and pc_o stays RESET_PC. Fetch of RESET_PC is therefore visible in the cycle after release.
- PC next-state when ce_o=1, highest priority first:
  - flush=1 → pc_o ← new_pc. Flush overrides stall.
  - else stall[0]=1 → hold pc_o.
  - else branch_flag_i=1 → pc_o ← {branch_target_address_i[ADDR_W-1:2], 2'b00}.
  - else pc_o ← pc_o + 4. Wraps modulo 2^ADDR_W.
- misaligned_o: 1 for exactly one cycle after an edge at which the branch redirect was taken (no flush, stall[0]=0, ce_o=1) and branch_target_address_i[1:0]≠0. Otherwise 0.
- IF/ID register, highest priority first:
  - flush=1 → id_pc_o=0, id_inst_o=0.
  - else stall[1]=1 and stall[2]=0 → bubble: id_pc_o=0, id_inst_o=0.
  - else stall[1]=1 and stall[2]=1 → hold.
  - else branch_flag_i=1 → squash the wrong-path instruction (no delay slot): id_pc_o=0, id_inst_o=0.
  - else capture: id_pc_o←pc_o, id_inst_o←inst_i if ce_o=1. If ce_o=0, load 0.
- fetch_count_o: increments by 1 on every capture edge with ce_o=1. Bubbles, squashes, holds and flushes do not count. Wraps from 0xFFFF_FFFF to 0.
- Simultaneous branch_flag_i and stall[0]: the branch is ignored. ID re-asserts branch_flag_i once the stall releases.
- rst asserted mid-run: all outputs return to reset values at the next edge, regardless of stall or flush.

Test Plan:
- Reset release, no stalls, ROM holds inst_mem[k]=k+1: pc_o goes 0,0,4,8,…. id_inst_o=1,2,3 on successive cycles starting two edges after release. fetch_count_o=3 after three captures.
- At pc_o=0x10, assert branch_flag_i with target 0x40 for one cycle: next pc_o=0x40. id_inst_o=0 for one cycle, then ROM[0x40>>2]. fetch_count_o does not increment on the squash cycle.
- Branch target 0x42: pc_o=0x40, misaligned_o=1 for exactly one cycle.
- stall=6'b000011 for 3 cycles at pc_o=0x8: pc_o holds 0x8. ID holds a bubble (id_pc_o=0, id_inst_o=0) for 3 cycles. On release, ID receives 0x8 and pc_o advances to 0xC.
- stall=6'b000111 with ID holding pc 0x4: id_pc_o/id_inst_o hold unchanged. Then flush=1 with new_pc=0x100 while stalled: next pc_o=0x100, ID zeroed.
- rst pulsed high for 1 cycle at pc_o=0x20: all outputs take reset values. PC sequence restarts at RESET_PC.
- Preload fetch_count_o to 0xFFFF_FFFF via one capture: it wraps to 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM and
// loads the IF/ID pipeline register consumed by decode.
module if_fetch_stage #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           INST_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              misaligned_o,
    output logic [31:0]       fetch_count_o
);

    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              misaligned;
    logic [31:0]       fetch_count;

    logic [ADDR_W-1:0] pc_next;
    logic              redirect;
    logic              bubble;
    logic              hold_id;

    // Only PC/IF/ID stall bits matter here; later-stage bits are ignored.
    logic unused_stall;
    assign unused_stall = ^stall[5:3];

    // A branch is only honoured when the PC is actually allowed to move.
    assign redirect = ce && !flush && !stall[0] && branch_flag_i;
    assign bubble   = stall[1] && !stall[2];
    assign hold_id  = stall[1] && stall[2];

    always_comb begin
        pc_next = pc + ADDR_W'(4);
        if (!ce) begin
            pc_next = RESET_PC;
        end else if (flush) begin
            pc_next = new_pc;
        end else if (stall[0]) begin
            pc_next = pc;
        end else if (branch_flag_i) begin
            pc_next = {branch_target_address_i[ADDR_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce          <= 1'b0;
            pc          <= RESET_PC;
            id_pc       <= '0;
            id_inst     <= '0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else begin
            ce         <= 1'b1;
            pc         <= pc_next;
            misaligned <= redirect && (branch_target_address_i[1:0] != 2'b00);

            if (flush || bubble) begin
                id_pc   <= '0;
                id_inst <= '0;
            end else if (hold_id) begin
                id_pc   <= id_pc;
                id_inst <= id_inst;
            end else if (branch_flag_i) begin
                // No delay slot: the instruction fetched alongside a taken branch is dropped.
                id_pc   <= '0;
                id_inst <= '0;
            end else if (ce) begin
                id_pc       <= pc;
                id_inst     <= inst_i;
                fetch_count <= fetch_count + 32'd1;
            end else begin
                id_pc   <= '0;
                id_inst <= '0;
            end
        end
    end

    assign pc_o          = pc;
    assign ce_o          = ce;
    assign id_pc_o       = id_pc;
    assign id_inst_o     = id_inst;
    assign misaligned_o  = misaligned;
    assign fetch_count_o = fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected state is queued when inputs
// are driven and compared one time unit after the following rising edge.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        misaligned_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_i                  (inst_i),
        .pc_o                    (pc_o),
        .ce_o                    (ce_o),
        .id_pc_o                 (id_pc_o),
        .id_inst_o               (id_inst_o),
        .misaligned_o            (misaligned_o),
        .fetch_count_o           (fetch_count_o)
    );

    always #5 clk = ~clk;

    // ROM contents: word k holds k+1
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'd1;
    endfunction

    assign inst_i = rom(pc_o);

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict the state after the coming edge from the inputs now driven.
    function automatic exp_t predict(input exp_t s);
        exp_t n;
        if (rst) begin
            n.ce = 1'b0; n.pc = RST_PC; n.id_pc = '0; n.id_inst = '0; n.mis = 1'b0; n.cnt = '0;
            return n;
        end
        n = s;
        n.ce  = 1'b1;
        n.mis = s.ce && !flush && !stall[0] && branch_flag_i && (branch_target_address_i[1:0] != 2'b00);
        if (!s.ce)                 n.pc = RST_PC;
        else if (flush)            n.pc = new_pc;
        else if (stall[0])         n.pc = s.pc;
        else if (branch_flag_i)    n.pc = branch_target_address_i & 32'hFFFF_FFFC;
        else                       n.pc = s.pc + 32'd4;

        if (flush || (stall[1] && !stall[2]) || (!stall[1] && branch_flag_i)) begin
            n.id_pc = '0; n.id_inst = '0;
        end else if (!stall[1]) begin
            n.id_pc   = s.ce ? s.pc : 32'd0;
            n.id_inst = s.ce ? rom(s.pc) : 32'd0;
            if (s.ce) n.cnt = s.cnt + 32'd1;
        end
        return n;
    endfunction

    task automatic cycle();
        exp_t e;
        m = predict(m);
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ce_o",          {31'd0, ce_o},         {31'd0, e.ce});
        check("pc_o",          pc_o,                  e.pc);
        check("id_pc_o",       id_pc_o,               e.id_pc);
        check("id_inst_o",     id_inst_o,             e.id_inst);
        check("misaligned_o",  {31'd0, misaligned_o}, {31'd0, e.mis});
        check("fetch_count_o", fetch_count_o,         e.cnt);
    endtask

    task automatic idle();
        stall = '0; flush = 0; new_pc = '0; branch_flag_i = 0; branch_target_address_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '{ce: 1'b0, pc: 32'hx, id_pc: 32'hx, id_inst: 32'hx, mis: 1'bx, cnt: 32'hx};
        rst = 1; idle();
        #1;
        cycle(); cycle();
        check("reset_pc", pc_o, RST_PC);
        check("reset_ce", {31'd0, ce_o}, 32'd0);

        rst = 0;
        cycle();
        check("first_fetch_ce", {31'd0, ce_o}, 32'd1);
        check("first_fetch_pc", pc_o, RST_PC);
        cycle(); cycle();
        check("pc_at_8", pc_o, 32'h8);
        check("count_two", fetch_count_o, 32'd2);

        // IF+PC stall with ID free: bubbles into decode
        stall = 6'b000011;
        repeat (3) begin
            cycle();
            check("stall_pc_hold", pc_o, 32'h8);
            check("stall_bubble",  id_pc_o, 32'h0);
        end
        stall = '0;
        cycle();
        check("release_id_pc", id_pc_o, 32'h8);
        check("release_pc",    pc_o, 32'hC);
        cycle();
        check("pc_at_10", pc_o, 32'h10);

        branch_flag_i = 1; branch_target_address_i = 32'h40;
        cycle();
        check("branch_pc", pc_o, 32'h40);
        check("squash_inst", id_inst_o, 32'h0);
        idle();
        cycle();
        check("target_inst", id_inst_o, rom(32'h40));

        branch_flag_i = 1; branch_target_address_i = 32'h42;
        cycle();
        check("misalign_pc",  pc_o, 32'h40);
        check("misalign_hi",  {31'd0, misaligned_o}, 32'd1);
        idle();
        cycle();
        check("misalign_lo",  {31'd0, misaligned_o}, 32'd0);

        // branch coincident with PC stall is dropped
        stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h80;
        cycle();
        idle();
        cycle(); cycle();

        stall = 6'b000111;
        repeat (2) cycle();
        flush = 1; new_pc = 32'h100;
        cycle();
        check("flush_pc", pc_o, 32'h100);
        check("flush_id", id_pc_o, 32'h0);
        idle();
        repeat (3) cycle();

        rst = 1; stall = 6'b000111; flush = 1; new_pc = 32'h200;
        cycle();
        check("midrun_rst_pc", pc_o, RST_PC);
        rst = 0; idle();
        repeat (3) cycle();

        repeat (300) begin
            rst           = ($urandom_range(0, 49) == 0);
            stall         = {3'($urandom), 3'($urandom_range(0, 7) & ($urandom_range(0, 2) == 0 ? 3'h7 : 3'h0))};
            flush         = ($urandom_range(0, 14) == 0);
            new_pc        = $urandom;
            branch_flag_i = ($urandom_range(0, 4) == 0);
            branch_target_address_i = $urandom;
            cycle();
        end

        // Counter wrap: seed the count at all-ones, then one capture
        rst = 0; idle();
        repeat (2) cycle();
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        m.cnt = 32'hFFFF_FFFF;
        cycle();
        check("count_wrap", fetch_count_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
